memory_round_ctrl: RTL
======================

Name: memory_round_ctrl

Overview:
- Sequences one round of the memorization game: latches a target digit pattern, runs a timed show phase, then collects keypad digits and compares them to the target.
- Sits between the keypad decoder (supplies one-cycle key strobes with 4-bit codes) and the game top level (supplies targets, consumes pass/fail and score).
- Owns the digit shift register, the entry count, the show and timeout timers, and the win-streak score.

Parameters:
- NUM_DIGITS, 4, digits per round; pattern width is 4*NUM_DIGITS.
- SHOW_CYCLES, 50000000, clk cycles the pattern is displayed (show_en high).
- TIMEOUT_CYCLES, 250000000, max clk cycles allowed between round entry/last accepted digit and the next digit.
- CNT_W, 28, timer width; must satisfy 2^CNT_W > max(SHOW_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  master clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  level; sampled only in IDLE; begins a round.
- target  in  4*NUM_DIGITS  pattern, nibble [3:0] = last digit; latched on accepted start.
- key_valid  in  1  one-cycle strobe from keypad decoder.
- key_code  in  4  key code, valid with key_valid; 0-9 digit, 0xC clear, others ignored.
- show_en  out  1  high throughout SHOW.
- entry  out  4*NUM_DIGITS  digits entered so far, newest in [3:0].
- entry_count  out  $clog2(NUM_DIGITS+1)  accepted digits this round.
- round_done  out  1  one-cycle pulse on entering RESULT.
- round_pass  out  1  result of last round; held until next accepted start.
- score  out  8  consecutive passed rounds, saturating at 255.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; entry=all 1s (0xF nibbles); entry_count=0; timers=0; show_en=0; round_done=0; round_pass=0; score=0; latched target=0.
- States: IDLE, SHOW, ENTER, CHECK, RESULT. busy=0 only in IDLE. Reset mid-round returns to IDLE immediately, with no round_done.
- IDLE: start=1 -> latch target, entry=all 1s, entry_count=0, round_pass=0, timer=0, next=SHOW. start in any other state is ignored.
- SHOW: show_en=1, timer increments. At timer==SHOW_CYCLES-1 -> timer=0, next=ENTER. Show lasts exactly SHOW_CYCLES cycles.
- Keys outside ENTER are discarded and not buffered.
- ENTER: timer increments each cycle.
- ENTER, key_valid with key_code<=9: entry={entry[4*NUM_DIGITS-5:0], key_code}; entry_count+1; timer=0.
  - If this makes entry_count==NUM_DIGITS, next=CHECK.
- ENTER, key_valid with key_code==0xC: entry=all 1s, entry_count=0, timer=0; state stays ENTER.
- ENTER, other key codes: ignored, timer not reset.
- ENTER timeout: timer==TIMEOUT_CYCLES-1 with no accepted digit/clear that cycle -> round_pass=0, next=RESULT (skips CHECK).
- Simultaneous final digit and timeout: the digit wins (-> CHECK).
- CHECK: one cycle. round_pass=(entry==latched target). next=RESULT. Latency from final digit strobe to round_done is 2 clk.
- RESULT: round_done=1 for exactly this cycle.
  - Pass: score=min(score+1,255).
  - Fail (mismatch or timeout): score=0.
  - next=IDLE.
- entry and entry_count hold their values in RESULT/IDLE until the next accepted start.
- Timer arithmetic is unsigned CNT_W; it never wraps because state changes at the terminal count.

Decomposition:
- Shared package game_pkg: state encoding enum (IDLE=0, SHOW=1, ENTER=2, CHECK=3, RESULT=4); key code constants KEY_CLEAR=4'hC, DIGIT_MAX=4'd9; EMPTY_NIBBLE=4'hF.
- One natural sub-module: round_timer (CNT_W up-counter with clear, enable, and terminal-count compare against a runtime limit), shared by SHOW and ENTER.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset/idle: rst low mid-SHOW -> state IDLE, show_en=0, entry=16'hFFFF, score=0, no round_done.
- Pass: start with target=16'h1234; show_en high exactly 4 cycles; strobe keys 1,2,3,4 -> round_done pulse 2 cycles after the '4' strobe, round_pass=1, score=1, entry=16'h1234.
- Mismatch: second round, target=16'h5678, keys 5,6,7,9 -> round_pass=0, score 1->0.
- Clear and ignored keys:
  - Keys 8, 0xC, 0xA, 2,4,6,8 with target=16'h2468 -> 0xA ignored, entry_count reset by 0xC.
  - Pass; keys strobed during SHOW have no effect.
- Timeout: enter 2 digits, then idle 20 cycles -> RESULT with round_pass=0, no CHECK state visited, entry_count=2.
- Edge cases:
  - Final digit on the same cycle as the timeout terminal count -> CHECK taken.
  - 255 consecutive passes followed by another pass -> score stays 255.

Source files
------------

// File: rtl/memory_round_ctrl_pkg.sv
// Shared types and constants for the memorization-game round controller.
package memory_round_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    ENTER  = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4
  } state_e;

  localparam logic [3:0] KEY_CLEAR    = 4'hC;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] EMPTY_NIBBLE = 4'hF;
  localparam logic [7:0] SCORE_MAX    = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SCORE_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/memory_round_ctrl_if.sv
// Game-side bus of the round controller: round control, keypad strobes and results.
interface memory_round_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  localparam int unsigned PAT_W = 4 * NUM_DIGITS;
  localparam int unsigned ECW   = $clog2(NUM_DIGITS + 1);

  logic             start;
  logic [PAT_W-1:0] target;
  logic             key_valid;
  logic [3:0]       key_code;
  logic             show_en;
  logic [PAT_W-1:0] entry;
  logic [ECW-1:0]   entry_count;
  logic             round_done;
  logic             round_pass;
  logic [7:0]       score;
  logic             busy;

  modport master (
    output start, target, key_valid, key_code,
    input  show_en, entry, entry_count, round_done, round_pass, score, busy
  );

  modport slave (
    input  start, target, key_valid, key_code,
    output show_en, entry, entry_count, round_done, round_pass, score, busy
  );
endinterface

// File: rtl/memory_round_ctrl_round_timer.sv
// Up-counter with synchronous clear/enable and terminal-count flag against a runtime limit.
module round_timer #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign tc_o = (count_q == limit_i);
endmodule

// File: rtl/memory_round_ctrl.sv
// One round of the memorization game: latch target, timed show, keypad entry, compare, score.
module memory_round_ctrl
  import memory_round_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SHOW_CYCLES    = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned CNT_W          = 28
) (
  input logic               clk,
  input logic               rst,
  memory_round_ctrl_if.slave bus
);
  localparam int unsigned      PAT_W      = 4 * NUM_DIGITS;
  localparam int unsigned      ECW        = $clog2(NUM_DIGITS + 1);
  localparam logic [PAT_W-1:0] EMPTY      = {NUM_DIGITS{EMPTY_NIBBLE}};
  localparam logic [ECW-1:0]   LAST_IDX   = ECW'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] target_q, target_d;
  logic [PAT_W-1:0] entry_q, entry_d;
  logic [ECW-1:0]   cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [7:0]       score_q, score_d;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic             digit_key, clear_key;

  round_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i ((state_q == SHOW) ? SHOW_LAST : TOUT_LAST),
    .tc_o    (tmr_tc)
  );

  assign digit_key = bus.key_valid && (bus.key_code <= DIGIT_MAX);
  assign clear_key = bus.key_valid && (bus.key_code == KEY_CLEAR);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    score_d  = score_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.target;
          entry_d  = EMPTY;
          cnt_d    = '0;
          pass_d   = 1'b0;
          tmr_clr  = 1'b1;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          state_d = ENTER;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ENTER: begin
        // An accepted key on the terminal-count cycle takes priority over the timeout.
        if (digit_key) begin
          entry_d = (entry_q << 4) | PAT_W'(bus.key_code);
          cnt_d   = cnt_q + ECW'(1);
          tmr_clr = 1'b1;
          if (cnt_q == LAST_IDX) state_d = CHECK;
        end else if (clear_key) begin
          entry_d = EMPTY;
          cnt_d   = '0;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          pass_d  = 1'b0;
          tmr_clr = 1'b1;
          state_d = RESULT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      CHECK: begin
        pass_d  = (entry_q == target_q);
        state_d = RESULT;
      end
      RESULT: begin
        score_d = pass_q ? sat_inc(score_q) : 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      entry_q  <= EMPTY;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      score_q  <= score_d;
    end
  end

  assign bus.show_en     = (state_q == SHOW);
  assign bus.round_done  = (state_q == RESULT);
  assign bus.busy        = (state_q != IDLE);
  assign bus.entry       = entry_q;
  assign bus.entry_count = cnt_q;
  assign bus.round_pass  = pass_q;
  assign bus.score       = score_q;
endmodule
